// File: rtl/arc_pkg.sv
// Shared definitions for the RC4 plaintext scanner: FSM state encoding and
// the accepted plaintext alphabet bounds.
package arc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: single-cycle pulse when i_sig is high and was low
// on the previous clock.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sig_q <= 1'b0;
    else       r_sig_q <= i_sig;
  end

  assign o_pulse = i_sig && !r_sig_q;

endmodule

// File: rtl/plaintext_scanner.sv
// Reads the decrypted message out of RAM-A, checks each byte against the
// plaintext alphabet and streams accepted bytes over a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for the first start edge
// READ  | aAddr holds idx, RAM-A access in flight
// LATCH | capture aOut into byte_q and classify it
// EMIT  | offer byte_q on the stream until accepted
// DONE  | verdict held until the next start edge
module plaintext_scanner
  import arc_pkg::*;
#(
  parameter int RAM_WIDTH          = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [MESSAGE_LOG_LENGTH-1:0] aAddr,
  input  logic [RAM_WIDTH-1:0]          aOut,
  output logic [RAM_WIDTH-1:0]          char_data,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          valid_msg,
  output logic [MESSAGE_LOG_LENGTH-1:0] bad_addr,
  output logic [MESSAGE_LOG_LENGTH:0]   char_count
);

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_IDX = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] IDX_ONE  = MESSAGE_LOG_LENGTH'(1);
  localparam logic [MESSAGE_LOG_LENGTH:0]   CNT_ONE  = (MESSAGE_LOG_LENGTH + 1)'(1);

  scan_state_t                   r_state;
  logic [MESSAGE_LOG_LENGTH-1:0] r_idx;
  logic [MESSAGE_LOG_LENGTH-1:0] r_addr;
  logic [RAM_WIDTH-1:0]          r_byte;
  logic                          r_valid;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_valid_msg;
  logic [MESSAGE_LOG_LENGTH-1:0] r_bad_addr;
  logic [MESSAGE_LOG_LENGTH:0]   r_count;
  logic                          w_start_pulse;
  logic                          w_accept;

  edge_detector u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (start),
    .o_pulse (w_start_pulse)
  );

  // Classify the word being captured this cycle so the verdict lands with it.
  assign w_accept = (aOut == RAM_WIDTH'(CHAR_SPACE)) ||
                    ((aOut >= RAM_WIDTH'(CHAR_LO)) && (aOut <= RAM_WIDTH'(CHAR_HI)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_byte      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid_msg <= 1'b0;
      r_bad_addr  <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_pulse) begin
            r_state     <= ST_READ;
            r_idx       <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_valid_msg <= 1'b0;
            r_bad_addr  <= '0;
            r_count     <= '0;
          end
        end
        ST_READ: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_byte <= aOut;
          if (w_accept) begin
            r_state <= ST_EMIT;
            r_valid <= 1'b1;
          end else begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_valid_msg <= 1'b0;
            r_bad_addr  <= r_idx;
          end
        end
        ST_EMIT: begin
          if (char_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + CNT_ONE;
            if (r_idx == LAST_IDX) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_valid_msg <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_addr  <= r_idx + IDX_ONE;
              r_state <= ST_READ;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign aAddr      = r_addr;
  assign char_data  = r_byte;
  assign char_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign valid_msg  = r_valid_msg;
  assign bad_addr   = r_bad_addr;
  assign char_count = r_count;

endmodule

// File: tb/tb_plaintext_scanner.sv
// Bench for plaintext_scanner: RAM-A model, stalling sink and a reference
// model that predicts the stream, verdict and done timing from the message.
module tb_plaintext_scanner;

  localparam int LEN = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] aAddr;
  logic [7:0] aOut;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       busy, done, valid_msg;
  logic [4:0] bad_addr;
  logic [5:0] char_count;

  logic [7:0] mem [LEN];
  int         stall_plan [LEN];
  string      alpha_s = "abcdefghijklmnopqrstuvwxyz ";
  int         total = 0;
  int         bad = 0;

  plaintext_scanner #(.RAM_WIDTH(8), .MESSAGE_LENGTH(LEN), .MESSAGE_LOG_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .aAddr(aAddr), .aOut(aOut),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .done(done), .valid_msg(valid_msg), .bad_addr(bad_addr),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) aOut <= mem[aAddr];

  function automatic bit is_alpha(input logic [7:0] b);
    for (int i = 0; i < alpha_s.len(); i++)
      if (b == alpha_s[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_alpha();
    return alpha_s[$urandom_range(0, 26)];
  endfunction

  function automatic logic [7:0] rand_non_alpha();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (is_alpha(b)) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic fill_alpha();
    for (int i = 0; i < LEN; i++) begin
      mem[i] = rand_alpha();
      stall_plan[i] = 0;
    end
  endtask

  // Runs one scan from a fresh start edge (edge 0 = first edge with start high).
  task automatic run_scan(input string tag, input bit toggle);
    logic [7:0] expq [$];
    bit         exp_ok;
    int         exp_bad, stalls, exp_edge;
    int         got, stall_left, done_edge, e;
    logic       pre_valid, pre_ready;
    logic [7:0] pre_data;
    exp_ok = 1'b1; exp_bad = 0; stalls = 0; done_edge = -1;
    for (int i = 0; i < LEN; i++) begin
      if (is_alpha(mem[i])) begin
        expq.push_back(mem[i]);
        stalls += stall_plan[i];
      end else begin
        exp_ok = 1'b0; exp_bad = i;
        break;
      end
    end
    exp_edge = stalls + (exp_ok ? 3 * LEN + 1 : 3 * expq.size() + 3);

    @(negedge clk); start = 1'b0; char_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    got = 0; stall_left = stall_plan[0];
    for (e = 0; e < 600 && done_edge < 0; e++) begin
      if (char_valid && stall_left > 0) begin
        char_ready = 1'b0; stall_left--;
      end else char_ready = 1'b1;
      pre_valid = char_valid; pre_ready = char_ready; pre_data = char_data;
      @(posedge clk); #1;
      if (e == 0) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || char_count !== 6'd0 || bad_addr !== 5'd0 ||
            valid_msg !== 1'b0 || aAddr !== 5'd0) begin
          bad++;
          $display("FAIL %s start_clear: busy=%0b done=%0b count=%0d bad_addr=%0d valid_msg=%0b aAddr=%0d, want busy=1 and the rest 0",
                   tag, busy, done, char_count, bad_addr, valid_msg, aAddr);
        end
      end
      if (pre_valid && pre_ready) begin
        total++;
        if (got >= expq.size()) begin
          bad++;
          $display("FAIL %s extra_transfer: byte %02h as transfer %0d, want only %0d transfers", tag, pre_data, got, expq.size());
        end else if (pre_data !== expq[got]) begin
          bad++;
          $display("FAIL %s stream_byte[%0d]: got %02h want %02h", tag, got, pre_data, expq[got]);
        end
        got++;
        stall_left = (got < LEN) ? stall_plan[got] : 0;
        total++;
        if (char_count !== 6'(got)) begin
          bad++;
          $display("FAIL %s count_track: got %0d want %0d", tag, char_count, got);
        end
      end else if (pre_valid) begin
        total++;
        if (char_valid !== 1'b1 || char_data !== pre_data) begin
          bad++;
          $display("FAIL %s stall_hold: valid=%0b data=%02h want valid=1 data=%02h", tag, char_valid, char_data, pre_data);
        end
      end
      if (done === 1'b1) done_edge = e + 1;
      @(negedge clk);
      if (toggle && e >= 1 && e < 40) start = 1'($urandom_range(0, 1));
      else start = 1'b1;
    end

    total++;
    if (done_edge != exp_edge) begin
      bad++;
      $display("FAIL %s done_edge: got %0d want %0d", tag, done_edge, exp_edge);
    end
    total++;
    if (got != expq.size() || char_count !== 6'(expq.size())) begin
      bad++;
      $display("FAIL %s transfers: got %0d (char_count=%0d) want %0d", tag, got, char_count, expq.size());
    end
    total++;
    if (valid_msg !== exp_ok || bad_addr !== 5'(exp_bad) || busy !== 1'b0 || char_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s verdict: valid_msg=%0b bad_addr=%0d busy=%0b char_valid=%0b want valid_msg=%0b bad_addr=%0d busy=0 char_valid=0",
               tag, valid_msg, bad_addr, busy, char_valid, exp_ok, exp_bad);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if (aAddr !== 5'd0 || char_data !== 8'd0 || char_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || valid_msg !== 1'b0 || bad_addr !== 5'd0 || char_count !== 6'd0) begin
      bad++;
      $display("FAIL reset_outputs: aAddr=%0d data=%02h valid=%0b busy=%0b done=%0b vmsg=%0b bad_addr=%0d count=%0d want all 0",
               aAddr, char_data, char_valid, busy, done, valid_msg, bad_addr, char_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_valid_message();
    string msg = "attack at dawn";
    for (int i = 0; i < LEN; i++) begin
      mem[i] = (i < msg.len()) ? msg[i] : 8'h20;
      stall_plan[i] = 0;
    end
    run_scan("valid_msg", 1'b0);
  endtask

  task automatic test_boundaries();
    logic [7:0] vals [7];
    vals = '{8'h7B, 8'h60, 8'h1F, 8'h21, 8'h20, 8'h61, 8'h7A};
    for (int v = 0; v < 7; v++) begin
      fill_alpha();
      mem[5] = vals[v];
      run_scan($sformatf("boundary_%02h", vals[v]), 1'b0);
    end
  endtask

  task automatic test_backpressure();
    fill_alpha();
    stall_plan[3] = 4;
    run_scan("backpressure", 1'b0);
  endtask

  task automatic test_first_byte_reject();
    fill_alpha();
    mem[0] = 8'h00;
    run_scan("first_reject", 1'b0);
  endtask

  task automatic test_start_handling();
    bit stray;
    fill_alpha();
    run_scan("start_toggle", 1'b1);
    stray = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b1 || char_count !== 6'd32 || char_valid !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL start_hold: rescan seen while start held, busy=%0b done=%0b count=%0d want 0/1/32", busy, done, char_count);
    end
  endtask

  task automatic test_back_to_back();
    fill_alpha();
    mem[9] = 8'h2E;
    run_scan("b2b_first", 1'b0);
    fill_alpha();
    run_scan("b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    int  n;
    bit  stray;
    fill_alpha();
    char_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    n = 0;
    while (!(char_valid === 1'b1 && char_count === 6'd10) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL mid_reset_reach: EMIT of byte 10 not seen, count=%0d want 10", char_count);
    end
    #2 reset = 1'b1; start = 1'b0;
    #1;
    total++;
    if (char_valid !== 1'b0 || busy !== 1'b0 || char_count !== 6'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: valid=%0b busy=%0b count=%0d done=%0b want all 0", char_valid, busy, char_count, done);
    end
    @(negedge clk); reset = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || char_valid !== 1'b0 || done !== 1'b0 || aAddr !== 5'd0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL mid_reset_quiet: activity after reset without start, busy=%0b valid=%0b done=%0b want 0", busy, char_valid, done);
    end
    fill_alpha();
    run_scan("after_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LEN; i++) begin
        mem[i] = ($urandom_range(0, 39) == 0) ? rand_non_alpha() : rand_alpha();
        stall_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_scan($sformatf("random_%0d", r), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) begin
      mem[i] = 8'h20;
      stall_plan[i] = 0;
    end
    test_reset();
    test_valid_message();
    test_boundaries();
    test_backpressure();
    test_first_byte_reject();
    test_start_handling();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plaintext_scanner.md
# plaintext_scanner

Downstream consumer of the RC4 decryption core. Once a decryption pass ends, it reads the decrypted message back out of RAM-A one byte at a time. Each byte is checked against the plaintext alphabet (lowercase a–z or space), and each accepted byte is streamed over a valid/ready channel to the display/UART sink. It reports a verdict, the accepted-byte count and, on failure, the address of the first offending byte.

## Interface
Parameters:
- RAM_WIDTH, 8, byte width of RAM-A words and of the output stream
- MESSAGE_LENGTH, 32, number of bytes in RAM-A to scan
- MESSAGE_LOG_LENGTH, 5, width of RAM-A address and index counters

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  single clock; all state changes on its rising edge
  - reset  in  1  asynchronous, active-high reset
- Control:
  - start  in  1  level input; a rising edge launches a scan; tied to the decryption core's finished/terminated flags
- RAM-A read port:
  - aAddr  out  MESSAGE_LOG_LENGTH  RAM-A read address, registered
  - aOut  in  RAM_WIDTH  RAM-A read data, valid one cycle after aAddr changes
- Output stream:
  - char_data  out  RAM_WIDTH  accepted plaintext byte
  - char_valid  out  1  char_data is offered
  - char_ready  in  1  sink accepts; a transfer occurs when valid && ready at a rising edge
- Status:
  - busy  out  1  scan in progress
  - done  out  1  scan complete; held high until the next accepted start
  - valid_msg  out  1  all MESSAGE_LENGTH bytes passed; meaningful only while done=1
  - bad_addr  out  MESSAGE_LOG_LENGTH  index of the first rejected byte; 0 if none
  - char_count  out  MESSAGE_LOG_LENGTH+1  number of bytes transferred on the stream

## Operation
- States:
  - IDLE: waits for a start rising edge (start high, start_q low).
  - READ: aAddr = idx.
  - LATCH: captures aOut into byte_q and classifies it.
  - EMIT: presents byte_q on the stream.
  - DONE: reports the verdict.
- Transitions:
  - IDLE → READ on a start edge. Entry clears done, valid_msg, bad_addr, char_count and idx, and sets busy.
  - DONE → READ on a start edge, with the same clears.
  - READ → LATCH unconditionally.
  - LATCH → EMIT if byte_q is 0x20 or in 0x61..0x7A.
  - LATCH → DONE otherwise, with valid_msg=0 and bad_addr=idx. A rejected byte is never streamed.
  - EMIT: hold while !char_ready. On transfer, char_count+1. Then:
    - if idx == MESSAGE_LENGTH-1: → DONE with valid_msg=1
    - else: idx+1 and → READ
- busy is high in READ, LATCH and EMIT. done is high only in DONE.
- A start edge while busy is ignored; no restart and no queuing. Holding start high never retriggers.
- idx never wraps. The final index is MESSAGE_LENGTH-1, and char_count reaches MESSAGE_LENGTH at most.

## Timing
- Reset: state=IDLE and start_q=0. All outputs are 0 immediately, without waiting for clk.
- Reset mid-scan aborts with no partial verdict. The next scan needs a fresh start edge after reset deasserts.
- Reference point: start edge sampled at edge 0. With char_ready held high, the scan then runs as follows:
  - Edge 1: READ for byte 0 (aAddr=0).
  - Edge 2: LATCH.
  - Edge 3: EMIT.
  - Byte k transfers at edge 3+3k.
  - A full valid message sets done at edge 3·MESSAGE_LENGTH+1, which is edge 97 for 32 bytes.
- A rejection at index k reaches DONE at edge 3k+3.
- Backpressure: char_data and char_valid are stable while in EMIT with !char_ready. Each stall cycle adds exactly one cycle. No duplicate and no dropped transfers.
- char_valid is registered. It deasserts in the cycle after the transfer edge.
- Each output stream byte corresponds to exactly one RAM-A read.

## Structure
- Shared package arc_pkg holds:
  - the scanner state enum
  - constants CHAR_SPACE=8'h20, CHAR_LO=8'h61, CHAR_HI=8'h7A
- Sub-module: the existing edge_detector (out = in && !in_q) generates the start pulse.
- Classification is a local combinational compare.

## Test plan
- Valid message: RAM-A = "attack at dawn" padded with spaces to 32 bytes, ready=1 → 32 transfers in order, done at edge 97, valid_msg=1, char_count=32, bad_addr=0.
- Alphabet boundaries: byte 5 = 0x7B → bytes 0–4 streamed, done at edge 18, valid_msg=0, bad_addr=5, char_count=5. Repeat with 0x60, 0x1F and 0x21 (rejected), and with 0x20, 0x61 and 0x7A (accepted).
- Backpressure: ready low for 4 cycles while byte 3 is offered → char_data constant across the stall, no duplicate, done at edge 101.
- Start handling: start pulses during busy and start held high for 200 cycles → exactly one scan. A new edge from DONE clears status and rescans from aAddr=0.
- Reset: async reset asserted mid-EMIT at byte 10 → char_valid, busy and char_count go to 0 before the next clk edge. After release, no activity until a start edge.
- First-byte rejection: byte 0 = 0x00 → zero transfers, done at edge 3, bad_addr=0, valid_msg=0, char_count=0.
